// File: rtl/fir_da_seq_ctrl_if.sv
// Signal bundle between the DA-FIR sequencer, its upstream/downstream streams
// and the bit-serial core. The sequencer takes the slave view.
interface fir_da_seq_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OUT  = 25,
  parameter int CNT_W   = $clog2(NB_DATA)
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] o_x;
  logic [CNT_W-1:0]   o_counter;
  logic               o_core_en;
  logic               o_core_rst;
  logic [NB_OUT-1:0]  i_y;
  logic [NB_OUT-1:0]  o_y;
  logic               o_y_valid;
  logic               i_y_ready;

  modport slave (
    input  i_data, i_valid, i_y, i_y_ready,
    output o_ready, o_x, o_counter, o_core_en, o_core_rst, o_y, o_y_valid
  );

  modport master (
    output i_data, i_valid, i_y, i_y_ready,
    input  o_ready, o_x, o_counter, o_core_en, o_core_rst, o_y, o_y_valid
  );
endinterface

// File: rtl/fir_da_seq_ctrl.sv
// Sequencer for the bit-serial DA FIR core: feeds one sample per serial pass,
// drives the core counter/gate/reset and returns each finished output downstream.
module fir_da_seq_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OUT  = 25,
  parameter int CNT_W   = $clog2(NB_DATA)
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fir_da_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {INIT, WAIT, LOAD, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_DATA - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NB_DATA - 2);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               init_done;
  logic               first_flag;
  logic               y_valid;
  logic [NB_DATA-1:0] x_reg;
  logic [NB_OUT-1:0]  y_reg;
  logic               slot, ready, accept, drain, capture;
  logic               core_en, core_rst;
  logic [CNT_W-1:0]   counter;

  // Accept slots are WAIT and the last RUN cycle; gating on the output register
  // here means a capture never lands on an undrained result.
  assign slot    = (state == WAIT) || ((state == RUN) && (cnt == CNT_END));
  assign ready   = slot && (!y_valid || bus.i_y_ready);
  assign accept  = bus.i_valid && ready;
  assign drain   = y_valid && bus.i_y_ready;
  assign capture = (state == RUN) && (cnt == '0);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    core_en   = 1'b1;
    core_rst  = 1'b0;
    counter   = CNT_LAST;
    case (state)
      INIT: begin
        core_rst = 1'b1;
        if (init_done) state_nxt = WAIT;
      end
      WAIT: begin
        core_en = 1'b0;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      RUN: begin
        counter = cnt;
        if (cnt == CNT_END) state_nxt = accept ? LOAD : WAIT;
        else                cnt_nxt   = cnt + CNT_W'(1);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == INIT) init_done <= 1'b1;
    end
  end

  // The core's first load after reset emits y for an empty history; drop it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_reg      <= '0;
      y_reg      <= '0;
      y_valid    <= 1'b0;
      first_flag <= 1'b1;
    end else begin
      if (accept) x_reg <= bus.i_data;
      if (drain) y_valid <= 1'b0;
      if (capture) begin
        if (first_flag) begin
          first_flag <= 1'b0;
        end else begin
          y_reg   <= bus.i_y;
          y_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_x        = x_reg;
  assign bus.o_counter  = counter;
  assign bus.o_core_en  = core_en;
  assign bus.o_core_rst = core_rst;
  assign bus.o_y        = y_reg;
  assign bus.o_y_valid  = y_valid;

endmodule

// File: doc/fir_da_seq_ctrl.md
# fir_da_seq_ctrl

Sequencer and stream adapter for the bit-serial distributed-arithmetic FIR core. It accepts parallel samples over a valid/ready handshake and presents each one to the core. It drives the core's bit-index counter, clock-gate enable and synchronous reset. It captures each completed filter output and returns it downstream over a second valid/ready handshake, so the core's free-running serial timing never leaks into the surrounding datapath.

## Interface
- NB_DATA, 8, sample width; must be a power of two; equals the serial pass length in cycles.
- NB_OUT, 25, core output width (NB_DATA + ROM word width).
- CNT_W, $clog2(NB_DATA), width of the bit-index counter.

- i_clk  in  1  system clock; the core's gated clock is derived from it using o_core_en.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  NB_DATA  signed input sample.
- i_valid  in  1  i_data valid.
- o_ready  out  1  sample accepted on an edge where i_valid && o_ready.
- o_x  out  NB_DATA  sample presented to the core x input.
- o_counter  out  CNT_W  bit index presented to the core counter input.
- o_core_en  out  1  clock-gate enable for the core clock.
- o_core_rst  out  1  synchronous active-high reset for the core.
- i_y  in  NB_OUT  core y output.
- o_y  out  NB_OUT  captured filter output.
- o_y_valid  out  1  o_y valid.
- i_y_ready  in  1  downstream accepts o_y on an edge where o_y_valid && i_y_ready.

## Operation
- The core loads o_x and updates y on any enabled edge with o_counter = NB_DATA-1 (the load edge). On other enabled edges it accumulates one bit.
- The y produced at a load edge is the output for the previous sample. It therefore emerges only when the next sample is loaded.
- States:
  - INIT: lasts 2 cycles after reset release. o_core_en=1, o_core_rst=1, o_counter=NB_DATA-1. Goes to WAIT.
  - WAIT: o_core_en=0, o_counter=NB_DATA-1. On accept, o_x <= i_data and state goes to LOAD.
  - LOAD: lasts 1 cycle. o_core_en=1, o_counter=NB_DATA-1; the core load edge ends this cycle. Goes to RUN with the counter at 0.
  - RUN: o_core_en=1, o_counter counts 0..NB_DATA-2, one step per cycle. After the NB_DATA-2 cycle, goes to LOAD if a sample was accepted in that cycle, otherwise to WAIT.
- o_ready = (WAIT, or RUN with o_counter = NB_DATA-2) && (!o_y_valid || i_y_ready). This slot rule guarantees the output register is free at capture time.
- Capture: on the edge ending the first RUN cycle (o_counter=0), o_y <= i_y and o_y_valid <= 1. The exception is the first load since reset: a first_flag is set by reset and cleared at that capture, and that output is discarded.
- o_y_valid clears on a downstream accept. o_y is held stable while o_y_valid && !i_y_ready.
- o_x is held constant from accept through the next accept.
- No arithmetic is performed: o_y is the bit-exact i_y; widths are unchanged.
- The core is never stalled mid-pass. o_core_en deasserts only in WAIT, with the counter parked at NB_DATA-1.

## Timing
- Reset values, applied asynchronously while i_rst_n=0:
  - o_ready=0, o_y_valid=0, o_y=0, o_x=0
  - o_counter=NB_DATA-1, o_core_en=1, o_core_rst=1
  - state=INIT, first_flag=1
- Reset mid-pass aborts the pass immediately. All outputs take their reset values and any pending output is dropped.
- Accept at edge T0 gives LOAD in cycle 1, RUN counter=0 in cycle 2, and o_y_valid=1 from cycle 3. That output belongs to the sample accepted before T0.
- Maximum throughput is one sample per NB_DATA cycles, achieved when i_valid and i_y_ready are held high. Accepts fall in RUN cycles with o_counter = NB_DATA-2.
- Simultaneous downstream drain and upstream accept in the same cycle are allowed; o_ready already accounts for i_y_ready.
- Idle gaps of any length are allowed. The core stays gated, and the output for the last sample waits for the next accept.

## Test plan
- Reset: hold i_rst_n=0 for 5 cycles with i_valid=1. Required: o_ready=0, o_y_valid=0, o_counter=7, o_core_en=1, o_core_rst=1. After release, o_core_rst stays 1 for 2 cycles, then o_ready=1 and o_core_en=0.
- Single sample 0x7F: counter runs 7,0,1..6 with o_core_en=1, then parks at 7 with o_core_en=0. o_y_valid never rises (first-output discard).
- Stream of 10 samples with i_valid=1 and i_y_ready=1: accepts spaced exactly 8 cycles apart. 9 outputs appear, each 3 cycles after the accept of the following sample. Each o_y equals i_y sampled in the cycle after the corresponding load edge and matches the golden FIR model.
- Backpressure: hold i_y_ready=0 while o_y_valid=1. Required: o_ready=0, the core parks in WAIT, o_y is stable. Raise i_y_ready: the accept happens in that same cycle and o_y_valid drops on that edge.
- Reset asserted in RUN at o_counter=3: outputs take reset values within the same cycle. After restart, the next first sample's output is discarded again.
- 20-cycle idle gap between samples 0x01 and 0x80: o_core_en=0 and o_counter=7 throughout the gap. The output for 0x01 appears 3 cycles after 0x80 is accepted.
